// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Bus-side bundle of the UART transmitter: write port, line config and status.
// Latency: n/a (wires only).
// Backpressure: full/overflow tell the master when writes are being dropped.
interface uart_tx_if #(
    parameter int DIV_W = 16
);
    import uart_pkg::*;

    logic                   wr_en;
    logic [UART_DATA_W-1:0] data_in;
    logic                   tx_en;
    logic [DIV_W-1:0]       baud_div;
    logic                   parity_en;
    logic                   parity_odd;
    logic                   two_stop;
    logic                   full;
    logic                   empty;
    logic                   busy;
    logic                   tx_done;
    logic                   overflow;

    modport master (
        output wr_en, data_in, tx_en, baud_div, parity_en, parity_odd, two_stop,
        input  full, empty, busy, tx_done, overflow
    );

    modport slave (
        input  wr_en, data_in, tx_en, baud_div, parity_en, parity_odd, two_stop,
        output full, empty, busy, tx_done, overflow
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the serialiser; head entry is readable combinationally.
// Latency: a push is visible (empty=0, head valid) the cycle after the write edge.
// Backpressure: writes while full are dropped and flagged by a 1-cycle overflow pulse.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_dat_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              overflow_q;
    logic              do_push;
    logic              do_pop;

    // Extra MSB on each pointer distinguishes a full wrap from empty.
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    // Full is judged before any same-edge pop, so a write at a full edge is lost.
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, do_pop};
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow_o = overflow_q;

    // Storage needs no reset: entries are only read once the pointers say valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

    // Pointer advance and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= push_i && full_o;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes serialised as start/8 data LSB-first/opt parity/1-2 stop.
// Latency: write into empty FIFO at E0 -> pop and tx falls at E1; frame = div*(10+parity+two_stop) clks.
// Backpressure: FIFO full drops writes (overflow pulse); tx_en=0 holds queued bytes after the current frame.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus,
    output logic     tx
);

    logic [UART_DATA_W-1:0] head_dat;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_ovf;

    tx_state_e              state_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic [2:0]             bit_idx_q;
    logic [DIV_W-1:0]       timer_q;
    logic [DIV_W-1:0]       div_q;
    logic                   par_en_q;
    logic                   par_bit_q;
    logic                   two_stop_q;
    logic                   stop2_q;
    logic                   tx_q;
    logic                   tx_done_q;

    logic [DIV_W-1:0]       eff_div;
    logic                   bit_end;
    logic                   stop_last;
    logic                   frame_end;
    logic                   pop;

    uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (UART_DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (bus.wr_en),
        .push_dat_i (bus.data_in),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_ovf)
    );

    // A zero divider would never end a bit; run it as one clock per bit.
    assign eff_div   = (bus.baud_div == '0) ? DIV_W'(1) : bus.baud_div;
    assign bit_end   = (timer_q == '0);
    assign stop_last = !two_stop_q || stop2_q;
    assign frame_end = (state_q == STOP) && bit_end && stop_last;
    // Pop from IDLE, or straight out of the last stop cycle for gapless frames.
    assign pop       = bus.tx_en && !fifo_empty && ((state_q == IDLE) || frame_end);

    assign tx           = tx_q;
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.overflow = fifo_ovf;
    assign bus.busy     = (state_q != IDLE);
    assign bus.tx_done  = tx_done_q;

    // Frame FSM with bit timer; tx and tx_done are registered (tx_done is set one edge early).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            timer_q    <= '0;
            div_q      <= DIV_W'(1);
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            if (!bit_end) begin
                timer_q <= timer_q - DIV_W'(1);
            end

            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                        bit_idx_q <= '0;
                        timer_q   <= div_q - DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer_q <= div_q - DIV_W'(1);
                        if (bit_idx_q == 3'd7) begin
                            if (par_en_q) begin
                                state_q <= PARITY;
                                tx_q    <= par_bit_q;
                            end else begin
                                state_q   <= STOP;
                                tx_q      <= 1'b1;
                                stop2_q   <= 1'b0;
                                tx_done_q <= (div_q == DIV_W'(1)) && !two_stop_q;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_q   <= STOP;
                        tx_q      <= 1'b1;
                        stop2_q   <= 1'b0;
                        timer_q   <= div_q - DIV_W'(1);
                        tx_done_q <= (div_q == DIV_W'(1)) && !two_stop_q;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (!stop_last) begin
                            stop2_q   <= 1'b1;
                            timer_q   <= div_q - DIV_W'(1);
                            tx_done_q <= (div_q == DIV_W'(1));
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (timer_q == DIV_W'(1) && stop_last) begin
                        tx_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase

            // Frame start overrides the case above; config is frozen here for the whole frame.
            if (pop) begin
                state_q    <= START;
                tx_q       <= 1'b0;
                shift_q    <= head_dat;
                par_bit_q  <= (^head_dat) ^ bus.parity_odd;
                div_q      <= eff_div;
                par_en_q   <= bus.parity_en;
                two_stop_q <= bus.two_stop;
                stop2_q    <= 1'b0;
                timer_q    <= eff_div - DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of expected frames checked cycle by cycle on tx.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx;

    typedef struct {
        logic [7:0] dat;
        int         div;
        bit         par_en;
        bit         par_odd;
        bit         two_stop;
        bit         b2b;
    } exp_t;

    logic clk;
    logic rst_n;
    logic tx;
    bit   mon_en;
    bit   mon_busy;
    int   n_cmp;
    int   n_err;
    exp_t exp_q[$];

    uart_tx_if #(.DIV_W(16)) bus ();

    uart_tx #(
        .DEPTH (8),
        .DIV_W (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .tx    (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic write_raw(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.data_in = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d, input int div, input bit pe, input bit po,
                             input bit ts, input bit b2b);
        exp_t e;
        e.dat      = d;
        e.div      = div;
        e.par_en   = pe;
        e.par_odd  = po;
        e.two_stop = ts;
        e.b2b      = b2b;
        exp_q.push_back(e);
        write_raw(d);
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", (n < max_cyc), 1);
        @(negedge clk);
    endtask

    // Monitor: on each start bit pop the expected frame and check every clock of it.
    initial begin : monitor
        exp_t e;
        logic b [12];
        int   nb;
        int   ones;
        int   total;
        bit   started;
        started  = 1'b0;
        mon_busy = 1'b0;
        forever begin
            if (!started) begin
                @(negedge clk);
                started = mon_en && (tx === 1'b0);
            end else begin
                started = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame_tx", tx, 1);
                end else begin
                    e        = exp_q.pop_front();
                    mon_busy = 1'b1;
                    b[0]     = 1'b0;
                    ones     = 0;
                    for (int i = 0; i < 8; i++) begin
                        b[1+i] = e.dat[i];
                        ones   = ones + int'(e.dat[i]);
                    end
                    nb = 9;
                    if (e.par_en) begin
                        b[nb] = ((ones % 2) == 1) ^ e.par_odd;
                        nb    = nb + 1;
                    end
                    b[nb] = 1'b1;
                    nb    = nb + 1;
                    if (e.two_stop) begin
                        b[nb] = 1'b1;
                        nb    = nb + 1;
                    end
                    total = nb * e.div;
                    for (int k = 0; k < total; k++) begin
                        if (k > 0) @(negedge clk);
                        chk("tx_bit", tx, b[k / e.div]);
                        chk("tx_done", bus.tx_done, (k == total - 1));
                        chk("busy_in_frame", bus.busy, 1);
                    end
                    @(negedge clk);
                    if (e.b2b) begin
                        chk("b2b_start", tx, 0);
                        started = (tx === 1'b0);
                    end else begin
                        chk("idle_tx", tx, 1);
                        chk("idle_busy", bus.busy, 0);
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        n_cmp          = 0;
        n_err          = 0;
        mon_en         = 1'b0;
        bus.wr_en      = 1'b0;
        bus.data_in    = 8'h00;
        bus.tx_en      = 1'b0;
        bus.baud_div   = 16'd4;
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;
        bus.two_stop   = 1'b0;
        rst_n          = 1'b1;
        #1 rst_n       = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tx_done", bus.tx_done, 0);
        chk("rst_overflow", bus.overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Async reset in the middle of DATA (byte 0x00 keeps tx low there)
        bus.tx_en = 1'b1;
        write_raw(8'h00);
        repeat (7) @(negedge clk);
        chk("pre_rst_tx_low", tx, 0);
        chk("pre_rst_busy", bus.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_empty", bus.empty, 1);
        chk("midrst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle_tx", tx, 1);
        mon_en = 1'b1;

        // 0xA5 at div 4, no parity, one stop; also the E0/E1 latency
        bus.baud_div = 16'd4;
        exp_q.push_back('{dat: 8'hA5, div: 4, par_en: 1'b0, par_odd: 1'b0, two_stop: 1'b0, b2b: 1'b0});
        bus.wr_en   = 1'b1;
        bus.data_in = 8'hA5;
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk("lat_empty_after_e0", bus.empty, 0);
        chk("lat_tx_high_after_e0", tx, 1);
        @(negedge clk);
        chk("lat_empty_after_pop", bus.empty, 1);
        wait_drain(200);

        // Parity on 0x07: even -> 1, odd -> 0
        bus.baud_div   = 16'd2;
        bus.parity_en  = 1'b1;
        bus.parity_odd = 1'b0;
        push_byte(8'h07, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain(200);
        bus.parity_odd = 1'b1;
        push_byte(8'h07, 2, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_drain(200);
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;

        // Fill to full with tx_en low, overflow on the 9th, then 8 gapless frames
        bus.tx_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_byte(8'(i), 2, 1'b0, 1'b0, 1'b0, (i != 7));
        end
        chk("fill_full", bus.full, 1);
        chk("fill_not_empty", bus.empty, 0);
        chk("fill_no_ovf", bus.overflow, 0);
        write_raw(8'h08);
        chk("ovf_pulse", bus.overflow, 1);
        chk("ovf_still_full", bus.full, 1);
        @(negedge clk);
        chk("ovf_pulse_end", bus.overflow, 0);
        bus.tx_en = 1'b1;
        wait_drain(600);
        chk("burst_empty", bus.empty, 1);
        chk("burst_not_full", bus.full, 0);

        // Two stop bits at div 3; divider changed mid-frame applies to next frame
        bus.baud_div = 16'd3;
        bus.two_stop = 1'b1;
        push_byte(8'h3C, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        push_byte(8'hC3, 5, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        bus.baud_div = 16'd5;
        wait_drain(300);
        bus.two_stop = 1'b0;

        // div 0 behaves as 1; dropping tx_en mid-frame leaves the queued byte
        bus.baud_div = 16'd0;
        push_byte(8'h5A, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_byte(8'h99, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.tx_en = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_byte_not_empty", bus.empty, 0);
        chk("held_byte_idle", bus.busy, 0);
        chk("held_byte_pending", exp_q.size(), 1);
        bus.tx_en = 1'b1;
        wait_drain(100);
        chk("final_empty", bus.empty, 1);
        chk("final_tx_idle", tx, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
